// File: rtl/disp_scan_bcd_ctrl.sv
// disp_scan_bcd_ctrl: loads a DATA_W-bit value (unsigned or two's complement),
// converts its magnitude to BCD with a one-bit-per-cycle double-dabble engine,
// and drives a time-multiplexed NUM_DIGITS-digit 7-segment display with
// leading-zero blanking, a minus sign and overflow dashes.
//
// Load handshake: a value is taken on any clk edge where load_valid and
// load_ready are both high. load_ready is low for the whole conversion and
// any load_valid seen while it is low is dropped, not queued.
module disp_scan_bcd_ctrl #(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 10000,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value_in,
  input  logic                  is_signed,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [NUM_DIGITS-1:0] digit,
  output logic [7:0]            seg_data,
  output logic                  overflow
);

  // Number of decimal digits needed for 2^w - 1.
  function automatic int calc_bcd_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (v > 0) begin
        n = n + 1;
        v = v / 10;
      end
    end
    return n;
  endfunction

  localparam int BCD_DIGITS = calc_bcd_digits(DATA_W);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W      = $clog2(SCAN_DIV);
  localparam int CNT_W      = $clog2(DATA_W);

  localparam logic [7:0] SEG_ZERO  = 8'hFC;
  localparam logic [7:0] SEG_MINUS = 8'h02;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Segment pattern {a,b,c,d,e,f,g,dp} for one decimal digit; dp stays off.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'hFC;
      4'd1:    seg_of = 8'h60;
      4'd2:    seg_of = 8'hDA;
      4'd3:    seg_of = 8'hF2;
      4'd4:    seg_of = 8'h66;
      4'd5:    seg_of = 8'hB6;
      4'd6:    seg_of = 8'hBE;
      4'd7:    seg_of = 8'hE0;
      4'd8:    seg_of = 8'hFE;
      4'd9:    seg_of = 8'hF6;
      default: seg_of = 8'h00;
    endcase
  endfunction

  // Highest BCD position holding a nonzero digit (0 for a zero value).
  function automatic int msd_of(input logic [BCD_W-1:0] b);
    int m;
    m = 0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) m = i;
    end
    return m;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mag;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_step;
  logic              neg_cap;
  logic [CNT_W-1:0]  bit_cnt;
  logic              commit_ovf;

  logic [BCD_W-1:0]  disp_bcd;
  logic              disp_neg;
  logic [BCD_W-1:0]  disp_bcd_nxt;
  logic              disp_neg_nxt;
  logic              ovf_nxt;

  logic [PRE_W-1:0]  prescaler;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              pre_last;

  int                seg_pos;
  int                seg_msd;
  logic [3:0]        seg_nib;
  logic [7:0]        seg_nxt;

  // One double-dabble step: correct nibbles >= 5, then shift in the next magnitude bit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_step   = {bcd_adj[BCD_W-2:0], mag[DATA_W-1]};
    commit_ovf = (msd_of(bcd) + 1 + int'(neg_cap)) > NUM_DIGITS;
  end

  // Conversion FSM: capture sign/magnitude, shift DATA_W times, commit to the display register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      mag        <= '0;
      bcd        <= '0;
      neg_cap    <= 1'b0;
      bit_cnt    <= '0;
      disp_bcd   <= '0;
      disp_neg   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_ready <= 1'b1;
          if (load_valid && load_ready) begin
            neg_cap    <= is_signed & value_in[DATA_W-1];
            // Negating the most negative value wraps back to itself, which is
            // exactly its unsigned magnitude.
            mag        <= (is_signed & value_in[DATA_W-1]) ? (DATA_W'(0) - value_in) : value_in;
            bcd        <= '0;
            bit_cnt    <= '0;
            load_ready <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          load_ready <= 1'b0;
          bcd        <= bcd_step;
          mag        <= {mag[DATA_W-2:0], 1'b0};
          bit_cnt    <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(DATA_W - 1)) state <= COMMIT;
        end
        COMMIT: begin
          disp_bcd   <= bcd;
          disp_neg   <= neg_cap;
          overflow   <= commit_ovf;
          load_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          load_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Display contents as they will be after this edge, so a commit shows on seg_data in the same cycle.
  always_comb begin
    disp_bcd_nxt = disp_bcd;
    disp_neg_nxt = disp_neg;
    ovf_nxt      = overflow;
    if (state == COMMIT) begin
      disp_bcd_nxt = bcd;
      disp_neg_nxt = neg_cap;
      ovf_nxt      = commit_ovf;
    end
  end

  // Next scan index: advances once per SCAN_DIV cycles and wraps after the last digit.
  always_comb begin
    pre_last = (prescaler == PRE_W'(SCAN_DIV - 1));
    idx_nxt  = scan_idx;
    if (pre_last) begin
      if (scan_idx == IDX_W'(NUM_DIGITS - 1)) idx_nxt = '0;
      else                                    idx_nxt = scan_idx + IDX_W'(1);
    end
  end

  // Segment pattern for the digit that will be active after this edge.
  always_comb begin
    seg_pos = int'(idx_nxt);
    seg_msd = msd_of(disp_bcd_nxt);
    seg_nib = 4'd0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (i == seg_pos) seg_nib = disp_bcd_nxt[4*i +: 4];
    end
    if (ovf_nxt)                                  seg_nxt = SEG_MINUS;
    else if (seg_pos <= seg_msd)                  seg_nxt = seg_of(seg_nib);
    else if (seg_pos == seg_msd + 1 && disp_neg_nxt) seg_nxt = SEG_MINUS;
    else if (BLANK_LZ)                            seg_nxt = SEG_BLANK;
    else                                          seg_nxt = SEG_ZERO;
  end

  // Free-running scan: prescaler, digit index and the registered digit/segment pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      scan_idx  <= '0;
      digit     <= NUM_DIGITS'(1);
      seg_data  <= SEG_ZERO;
    end else begin
      prescaler <= pre_last ? '0 : prescaler + PRE_W'(1);
      scan_idx  <= idx_nxt;
      digit     <= NUM_DIGITS'(1) << idx_nxt;
      seg_data  <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_disp_scan_bcd_ctrl.sv
// Bench for disp_scan_bcd_ctrl: three instances (8 digits blanking, 3 digits
// blanking, 8 digits with leading zeros) share one load stream. A table of
// hand-computed patterns plus randomized loads are checked against a
// decimal-arithmetic model of what each display should show.
module tb_disp_scan_bcd_ctrl;

  localparam int SDIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] value_in = 8'd0;
  logic       is_signed = 1'b0;
  logic       load_valid = 1'b0;

  logic       ready_a, ready_b, ready_c;
  logic [7:0] digit_a, digit_c;
  logic [2:0] digit_b;
  logic [7:0] seg_a, seg_b, seg_c;
  logic       ovf_a, ovf_b, ovf_c;

  disp_scan_bcd_ctrl #(.DATA_W(8), .NUM_DIGITS(8), .SCAN_DIV(SDIV), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .reset(reset), .value_in(value_in), .is_signed(is_signed),
    .load_valid(load_valid), .load_ready(ready_a), .digit(digit_a),
    .seg_data(seg_a), .overflow(ovf_a));

  disp_scan_bcd_ctrl #(.DATA_W(8), .NUM_DIGITS(3), .SCAN_DIV(SDIV), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .reset(reset), .value_in(value_in), .is_signed(is_signed),
    .load_valid(load_valid), .load_ready(ready_b), .digit(digit_b),
    .seg_data(seg_b), .overflow(ovf_b));

  disp_scan_bcd_ctrl #(.DATA_W(8), .NUM_DIGITS(8), .SCAN_DIV(SDIV), .BLANK_LZ(1'b0)) dut_c (
    .clk(clk), .reset(reset), .value_in(value_in), .is_signed(is_signed),
    .load_valid(load_valid), .load_ready(ready_c), .digit(digit_c),
    .seg_data(seg_c), .overflow(ovf_c));

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
      4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE0;
      8: return 8'hFE;  9: return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int num_sig(input int mag);
    int n;
    int m;
    n = 1;
    m = mag / 10;
    while (m > 0) begin
      n++;
      m = m / 10;
    end
    return n;
  endfunction

  function automatic int to_int(input logic [7:0] v, input logic s);
    if (s && v[7]) return int'(v) - 256;
    return int'(v);
  endfunction

  function automatic logic model_ovf(input int v, input int nd);
    int mag;
    mag = (v < 0) ? -v : v;
    return (num_sig(mag) + ((v < 0) ? 1 : 0)) > nd;
  endfunction

  function automatic logic [7:0] model_seg(input int v, input int nd, input bit blank, input int p);
    int mag;
    int nsig;
    int pw;
    bit neg;
    neg  = (v < 0);
    mag  = neg ? -v : v;
    nsig = num_sig(mag);
    if (nsig + (neg ? 1 : 0) > nd) return 8'h02;
    if (p < nsig) begin
      pw = 1;
      for (int i = 0; i < p; i++) pw = pw * 10;
      return seg_code((mag / pw) % 10);
    end
    if (p == nsig && neg) return 8'h02;
    return blank ? 8'h00 : 8'hFC;
  endfunction

  // Edges since reset release; drives the scan position model.
  int edge_cnt = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  int cur_val = 0;
  int pend_val = 0;
  int pend_edge = 0;
  bit pend_valid = 1'b0;
  int ready_edge = 0;
  bit chk_on = 1'b0;
  int idx8, idx3;

  // Continuous checker: every cycle, every instance's pins against the model.
  always @(negedge clk) begin
    if (reset && chk_on) begin
      if (pend_valid && edge_cnt >= pend_edge) begin
        cur_val    = pend_val;
        pend_valid = 1'b0;
      end
      idx8 = (edge_cnt / SDIV) % 8;
      idx3 = (edge_cnt / SDIV) % 3;
      check("digit_a", digit_a, 64'd1 << idx8);
      check("digit_b", digit_b, 64'd1 << idx3);
      check("digit_c", digit_c, 64'd1 << idx8);
      check("seg_a", seg_a, model_seg(cur_val, 8, 1'b1, idx8));
      check("seg_b", seg_b, model_seg(cur_val, 3, 1'b1, idx3));
      check("seg_c", seg_c, model_seg(cur_val, 8, 1'b0, idx8));
      check("ovf_a", ovf_a, model_ovf(cur_val, 8));
      check("ovf_b", ovf_b, model_ovf(cur_val, 3));
      check("ovf_c", ovf_c, model_ovf(cur_val, 8));
      check("ready_a", ready_a, edge_cnt >= ready_edge);
      check("ready_b", ready_b, edge_cnt >= ready_edge);
      check("ready_c", ready_c, edge_cnt >= ready_edge);
    end
  end

  // ---------------- driver ----------------
  // Waits until the model says the block is ready, presents one value and
  // records when it must appear. With junk set, load_valid stays high one more
  // cycle with a different value, which must be ignored.
  task automatic do_load(input logic [7:0] v, input logic s, input bit junk);
    @(posedge clk); #1;
    while (edge_cnt < ready_edge) begin
      @(posedge clk); #1;
    end
    value_in   = v;
    is_signed  = s;
    load_valid = 1'b1;
    @(posedge clk); #1;
    pend_val   = to_int(v, s);
    pend_edge  = edge_cnt + 9;
    pend_valid = 1'b1;
    ready_edge = edge_cnt + 9;
    if (junk) begin
      value_in  = ~v;
      is_signed = ~s;
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
  endtask

  task automatic wait_done();
    @(negedge clk);
    while (edge_cnt < ready_edge) @(negedge clk);
  endtask

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [7:0]  val;
    logic        sgn;
    logic [63:0] exp_a;   // byte p = pattern of digit position p
    logic        ovf_a;
    logic [23:0] exp_b;
    logic        ovf_b;
    logic [63:0] exp_c;
  } vec_t;

  vec_t tbl [9];
  vec_t t;
  logic [63:0] ea, ec;
  logic [23:0] eb;
  int p8, p3;

  initial begin
    tbl[0] = '{8'd123, 1'b0, 64'h00000000_0060DAF2, 1'b0, 24'h60DAF2, 1'b0, 64'hFCFCFCFC_FC60DAF2};
    tbl[1] = '{8'hFB,  1'b1, 64'h00000000_000002B6, 1'b0, 24'h0002B6, 1'b0, 64'hFCFCFCFC_FCFC02B6};
    tbl[2] = '{8'h80,  1'b1, 64'h00000000_0260DAFE, 1'b0, 24'h020202, 1'b1, 64'hFCFCFCFC_0260DAFE};
    tbl[3] = '{8'd7,   1'b0, 64'h00000000_000000E0, 1'b0, 24'h0000E0, 1'b0, 64'hFCFCFCFC_FCFCFCE0};
    tbl[4] = '{8'd9,   1'b0, 64'h00000000_000000F6, 1'b0, 24'h0000F6, 1'b0, 64'hFCFCFCFC_FCFCFCF6};
    tbl[5] = '{8'd0,   1'b1, 64'h00000000_000000FC, 1'b0, 24'h0000FC, 1'b0, 64'hFCFCFCFC_FCFCFCFC};
    tbl[6] = '{8'd255, 1'b0, 64'h00000000_00DAB6B6, 1'b0, 24'hDAB6B6, 1'b0, 64'hFCFCFCFC_FCDAB6B6};
    tbl[7] = '{8'hFF,  1'b1, 64'h00000000_00000260, 1'b0, 24'h000260, 1'b0, 64'hFCFCFCFC_FCFC0260};
    tbl[8] = '{8'h9C,  1'b1, 64'h00000000_0260FCFC, 1'b0, 24'h020202, 1'b1, 64'hFCFCFCFC_0260FCFC};

    // Reset values, held over two clock edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_digit_a", digit_a, 64'h01);
    check("rst_digit_b", digit_b, 64'h1);
    check("rst_digit_c", digit_c, 64'h01);
    check("rst_seg_a", seg_a, 64'hFC);
    check("rst_seg_b", seg_b, 64'hFC);
    check("rst_seg_c", seg_c, 64'hFC);
    check("rst_ready_a", ready_a, 64'd1);
    check("rst_ready_b", ready_b, 64'd1);
    check("rst_ovf_a", ovf_a, 64'd0);
    check("rst_ovf_b", ovf_b, 64'd0);
    #1;
    reset  = 1'b1;
    chk_on = 1'b1;

    // Scan alone for a full wrap of the 8-digit instances.
    repeat (40) @(posedge clk);

    // Table-driven loads; each is swept across a full scan cycle.
    for (int k = 0; k < 9; k++) begin
      t = tbl[k];
      do_load(t.val, t.sgn, 1'b0);
      wait_done();
      ea = t.exp_a;
      eb = t.exp_b;
      ec = t.exp_c;
      check("tbl_ovf_a", ovf_a, t.ovf_a);
      check("tbl_ovf_b", ovf_b, t.ovf_b);
      repeat (8 * SDIV) begin
        @(negedge clk);
        p8 = (edge_cnt / SDIV) % 8;
        p3 = (edge_cnt / SDIV) % 3;
        check("tbl_seg_a", seg_a, ea[p8*8 +: 8]);
        check("tbl_seg_b", seg_b, eb[p3*8 +: 8]);
        check("tbl_seg_c", seg_c, ec[p8*8 +: 8]);
      end
    end

    // Reset in the middle of a conversion while -100 (overflow on 3 digits) is shown.
    do_load(8'd77, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk_on = 1'b0;
    reset  = 1'b0;
    #1;
    check("mid_rst_ready_a", ready_a, 64'd1);
    check("mid_rst_seg_a", seg_a, 64'hFC);
    check("mid_rst_seg_b", seg_b, 64'hFC);
    check("mid_rst_digit_a", digit_a, 64'h01);
    check("mid_rst_ovf_b", ovf_b, 64'd0);
    pend_valid = 1'b0;
    cur_val    = 0;
    ready_edge = 0;
    @(negedge clk); #1;
    reset  = 1'b1;
    chk_on = 1'b1;
    repeat (12) @(posedge clk);

    // Busy load: 55 presented the cycle after 200 is taken must be dropped.
    do_load(8'd200, 1'b0, 1'b0);
    value_in   = 8'd55;
    is_signed  = 1'b0;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_done();
    repeat (8 * SDIV) begin
      @(negedge clk);
      p8 = (edge_cnt / SDIV) % 8;
      check("busy_seg_a", seg_a, model_seg(200, 8, 1'b1, p8));
    end

    // Randomized loads with random gaps and occasional ignored busy requests.
    for (int k = 0; k < 24; k++) begin
      do_load(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 14)) @(posedge clk);
    end
    wait_done();
    repeat (8 * SDIV) @(negedge clk);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
